// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU sequencer and datapath controller:
// state encoding plus the opcode/regimm values the sequencer classifies on.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        ST_HALTED = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC1  = 3'd3,
        ST_EXEC2  = 3'd4
    } state_t;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [4:0] RI_BLTZAL = 5'h10;
    localparam logic [4:0] RI_BGEZAL = 5'h11;

endpackage

// File: rtl/mips_cpu_instr_class.sv
// Combinational instruction classifier: flags two-cycle instructions and
// opcodes that issue a data-memory access (and can therefore be stalled).
module mips_cpu_instr_class
    import mips_cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] regimm,
    output logic       two_cycle,
    output logic       is_mem
);

    logic link_branch;

    always_comb begin
        link_branch = (opcode == OP_REGIMM) &&
                      ((regimm == RI_BLTZAL) || (regimm == RI_BGEZAL));
        is_mem      = (opcode == OP_LW) || (opcode == OP_SB) ||
                      (opcode == OP_SH) || (opcode == OP_SW);
        two_cycle   = (opcode == OP_LW) || link_branch;
    end

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Multi-cycle MIPS instruction sequencer: FETCH/DECODE/EXEC1/EXEC2 stepping,
// memory-stall handling, halt on a zero next-PC and a retired-instruction count.
module mips_cpu_sequencer
    import mips_cpu_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [4:0]  regimm,
    input  logic        waitrequest,
    input  logic [31:0] pc_next,
    output logic [2:0]  state,
    output logic        active,
    output logic [31:0] instr_count
);

    localparam logic [2:0] S_HALTED = ST_HALTED;
    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_DECODE = ST_DECODE;
    localparam logic [2:0] S_EXEC1  = ST_EXEC1;
    localparam logic [2:0] S_EXEC2  = ST_EXEC2;

    logic       two_cycle;
    logic       is_mem;
    logic [2:0] state_next;
    logic [2:0] retire_target;
    logic       retire;

    mips_cpu_instr_class u_class (
        .opcode    (opcode),
        .regimm    (regimm),
        .two_cycle (two_cycle),
        .is_mem    (is_mem)
    );

    // Classification is only consulted in EXEC1; other states ignore opcode.
    always_comb begin
        state_next    = state;
        retire        = 1'b0;
        retire_target = (pc_next == 32'h0) ? S_HALTED : S_FETCH;
        case (state)
            S_HALTED: state_next = S_HALTED;
            S_FETCH:  state_next = waitrequest ? S_FETCH : S_DECODE;
            S_DECODE: state_next = S_EXEC1;
            S_EXEC1: begin
                if (is_mem && waitrequest) begin
                    state_next = S_EXEC1;
                end else if (two_cycle) begin
                    state_next = S_EXEC2;
                end else begin
                    state_next = retire_target;
                    retire     = 1'b1;
                end
            end
            S_EXEC2: begin
                state_next = retire_target;
                retire     = 1'b1;
            end
            default: state_next = S_HALTED;
        endcase
    end

    // active is registered alongside state so neither has a path from inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RESET_STATE;
            active      <= 1'b1;
            instr_count <= 32'h0;
        end else begin
            state  <= state_next;
            active <= (state_next != S_HALTED);
            if (retire) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Randomized self-checking bench for mips_cpu_sequencer; expected states are
// derived per instruction from the sequencing rules, not from the RTL.
module tb_mips_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'h0;
    logic [4:0]  regimm = 5'h0;
    logic        waitrequest = 1'b0;
    logic [31:0] pc_next = 32'h4;
    logic [2:0]  state;
    logic        active;
    logic [31:0] instr_count;
    logic [2:0]  ill_state;
    logic        ill_active;
    logic [31:0] ill_count;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_count = 32'h0;

    localparam logic [2:0] E_HALTED = 3'd0;
    localparam logic [2:0] E_FETCH  = 3'd1;
    localparam logic [2:0] E_DECODE = 3'd2;
    localparam logic [2:0] E_EXEC1  = 3'd3;
    localparam logic [2:0] E_EXEC2  = 3'd4;

    always #5 clk = ~clk;

    mips_cpu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .regimm      (regimm),
        .waitrequest (waitrequest),
        .pc_next     (pc_next),
        .state       (state),
        .active      (active),
        .instr_count (instr_count)
    );

    // Reset lands in an illegal code, which must fall to HALTED.
    mips_cpu_sequencer #(.RESET_STATE(3'd5)) dut_ill (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .regimm      (regimm),
        .waitrequest (waitrequest),
        .pc_next     (pc_next),
        .state       (ill_state),
        .active      (ill_active),
        .instr_count (ill_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] exp_st);
        check_val({tag, " state"}, {29'h0, state}, {29'h0, exp_st});
        check_val({tag, " active"}, {31'h0, active}, {31'h0, exp_st != E_HALTED});
        check_val({tag, " count"}, instr_count, model_count);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic wr, input logic [5:0] op, input logic [4:0] ri,
                        input logic [31:0] pcn, input logic [2:0] exp_st, input string tag);
        waitrequest = wr;
        opcode      = op;
        regimm      = ri;
        pc_next     = pcn;
        @(posedge clk);
        #1;
        check_all(tag, exp_st);
    endtask

    task automatic do_reset(input logic wr, input logic [5:0] op);
        reset       = 1'b1;
        waitrequest = wr;
        opcode      = op;
        pc_next     = 32'h0;
        @(posedge clk);
        #1;
        model_count = 32'h0;
        check_all("reset", E_FETCH);
        reset = 1'b0;
    endtask

    // One instruction: fs fetch stalls, es memory stalls in EXEC1 (if memory op).
    task automatic run_instr(input logic [5:0] op, input logic [4:0] ri, input int fs,
                             input int es, input logic [31:0] pcn, input string tag);
        logic       two;
        logic       mem;
        logic [2:0] fin;
        two = (op == 6'h23) || (op == 6'h01 && (ri == 5'h10 || ri == 5'h11));
        mem = (op == 6'h23) || (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
        fin = (pcn == 32'h0) ? E_HALTED : E_FETCH;
        for (int i = 0; i < fs; i++)
            step(1'b1, 6'($urandom), 5'($urandom), $urandom, E_FETCH, {tag, " fetch-stall"});
        step(1'b0, 6'($urandom), 5'($urandom), $urandom, E_DECODE, {tag, " fetch"});
        step(rbit(), 6'($urandom), 5'($urandom), $urandom, E_EXEC1, {tag, " decode"});
        if (mem) begin
            for (int i = 0; i < es; i++)
                step(1'b1, op, ri, pcn, E_EXEC1, {tag, " exec1-stall"});
        end
        if (two) begin
            step(mem ? 1'b0 : rbit(), op, ri, pcn, E_EXEC2, {tag, " exec1"});
            model_count = model_count + 32'd1;
            step(rbit(), op, ri, pcn, fin, {tag, " exec2"});
        end else begin
            model_count = model_count + 32'd1;
            step(mem ? 1'b0 : rbit(), op, ri, pcn, fin, {tag, " exec1"});
        end
    endtask

    logic [5:0] op_pool [10] = '{6'h23, 6'h28, 6'h29, 6'h2B, 6'h01,
                                 6'h01, 6'h00, 6'h09, 6'h04, 6'h0F};

    initial begin
        logic [5:0] rop;
        logic [4:0] rri;
        logic [31:0] frozen;

        do_reset(1'b0, 6'h00);
        check_val("illegal reset state", {29'h0, ill_state}, 32'd5);
        check_val("illegal reset active", {31'h0, ill_active}, 32'd1);

        run_instr(6'h09, 5'h00, 0, 0, 32'h4, "addiu");
        check_val("illegal to halted", {29'h0, ill_state}, 32'd0);
        check_val("illegal inactive", {31'h0, ill_active}, 32'd0);
        check_val("illegal no count", ill_count, 32'd0);

        run_instr(6'h23, 5'h00, 0, 3, 32'h8, "lw-stall");
        run_instr(6'h01, 5'h11, 2, 0, 32'hC, "bgezal");
        run_instr(6'h01, 5'h10, 0, 0, 32'h10, "bltzal");
        run_instr(6'h01, 5'h01, 1, 0, 32'h14, "bgez");
        run_instr(6'h2B, 5'h00, 0, 2, 32'h18, "sw-stall");

        for (int n = 0; n < 40; n++) begin
            rop = op_pool[$urandom_range(0, 9)];
            rri = rbit() ? (5'h10 + 5'($urandom_range(0, 1))) : 5'($urandom);
            run_instr(rop, rri, $urandom_range(0, 2), $urandom_range(0, 3),
                      $urandom | 32'h4, "random");
        end

        step(1'b0, 6'h2B, 5'h0, 32'h20, E_DECODE, "sw-abort fetch");
        step(1'b1, 6'h2B, 5'h0, 32'h20, E_EXEC1, "sw-abort decode");
        step(1'b1, 6'h2B, 5'h0, 32'h20, E_EXEC1, "sw-abort stall1");
        step(1'b1, 6'h2B, 5'h0, 32'h20, E_EXEC1, "sw-abort stall2");
        do_reset(1'b1, 6'h2B);

        force dut.instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count;
        model_count = 32'hFFFF_FFFF;
        run_instr(6'h09, 5'h00, 0, 0, 32'h8, "wrap");
        check_val("wrap to zero", instr_count, 32'h0);

        run_instr(6'h00, 5'h00, 0, 0, 32'h0, "jr-halt");
        frozen = model_count;
        for (int i = 0; i < 10; i++)
            step(rbit(), 6'($urandom), 5'($urandom), $urandom, E_HALTED, "halted");
        check_val("halted count frozen", instr_count, frozen);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
